icache_fill_controller: RTL and testbench
=========================================

Name: icache_fill_controller

Overview:
- Sequences the instruction cache arrays for the fetch stage.
- Looks up each fetch address against the external tag/data arrays and returns the word on a hit.
- On a miss, issues a line-aligned burst read to memory, writes each returned word into the data array, then sets the line's tag and valid bit.
- Also runs a full-cache invalidate sweep on request.
- Sits between the fetch unit, the cache arrays and the memory port.

Parameters:
- ADDR_W, 32, fetch/memory address width.
- DATA_W, 32, instruction word width.
- NUM_LINES, 32, cache lines (power of 2); IDX_W = clog2(NUM_LINES).
- WORDS_PER_LINE, 4, words per line (power of 2); OFF_W = clog2(WORDS_PER_LINE); TAG_W = ADDR_W-IDX_W-OFF_W-2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- fetch_req_valid  in  1  fetch request.
- fetch_req_ready  out  1  controller accepts a request.
- fetch_req_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- fetch_rsp_valid  out  1  one-cycle response pulse; fetch always accepts.
- fetch_rsp_data  out  DATA_W  returned instruction.
- cache_lookup_index  out  IDX_W  array read index.
- cache_lookup_offset  out  OFF_W  array read word offset.
- cache_lookup_tag  out  TAG_W  tag under lookup/fill.
- cache_hit  in  1  combinational tag match AND valid for the lookup index/tag.
- cache_rd_data  in  DATA_W  combinational data at the lookup index/offset.
- cache_wr_en  out  1  data-array write strobe.
- cache_wr_index  out  IDX_W  write line index.
- cache_wr_offset  out  OFF_W  write word offset.
- cache_wr_data  out  DATA_W  write data.
- cache_tag_wr_en  out  1  writes cache_lookup_tag and sets valid at cache_wr_index.
- cache_inv_en  out  1  clears valid at cache_inv_index.
- cache_inv_index  out  IDX_W  line index being invalidated.
- mem_req_valid  out  1  line read request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_W  line-aligned address (offset and byte bits zero).
- mem_rsp_valid  in  1  one beat of read data, in ascending word order.
- mem_rsp_data  in  DATA_W  beat data.
- flush  in  1  request a full invalidate; level-sampled, latched.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States and transitions:
  - IDLE: a latched flush goes to FLUSH (flush has priority over fetch). Otherwise a fetch handshake latches the address and goes to LOOKUP.
  - LOOKUP: on cache_hit, register cache_rd_data and go to RESP. On miss, go to MEM_REQ.
  - MEM_REQ: hold mem_req_valid and mem_req_addr stable until mem_req_ready, then go to FILL.
  - FILL: each mem_rsp_valid beat drives cache_wr_en=1 with offset = beat count 0..WORDS_PER_LINE-1. When beat count equals the requested offset, capture that beat as the response. On the last beat, also assert cache_tag_wr_en in the same cycle and go to RESP.
  - RESP: pulse fetch_rsp_valid for 1 cycle, then go to IDLE.
  - FLUSH: cache_inv_en=1, cache_inv_index counts 0..NUM_LINES-1 (one line per cycle), then go to IDLE and clear the flush latch.
- fetch_req_ready = (state==IDLE) && !flush_pending && !flush.
- Hit latency: request accepted at edge T; LOOKUP during T+1; fetch_rsp_valid high during T+2.
- Miss latency: 2 + memory handshake wait + WORDS_PER_LINE beats + 1 cycles.
- flush asserted in any non-IDLE state sets flush_pending. The current transaction completes normally; the sweep starts from IDLE.
- mem_rsp_valid outside FILL is ignored: no write, no state change.
- Beat and flush counters wrap only by construction; beats beyond WORDS_PER_LINE cannot occur in FILL because the state exits on the last beat.
- Reset, asynchronous and valid at any point including mid-fill or mid-flush:
  - State returns to IDLE; counters and flush_pending clear.
  - All outputs are 0, except fetch_req_ready, which is 1 once reset deasserts.
  - A partially filled line keeps its valid bit clear, so it is never hit.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- With the macro: adds output ports hit_count and miss_count, each 32 bits. hit_count increments on a LOOKUP hit; miss_count increments on a LOOKUP miss. Both wrap at 2^32 and clear on reset.
- Without the macro: these ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Shared package icache_pkg holds:
  - the state enum icache_state_t (IDLE, LOOKUP, MEM_REQ, FILL, RESP, FLUSH);
  - the field-width constants (IDX_W, OFF_W, TAG_W);
  - address-split helper functions (tag/index/offset).
- One sub-module, icache_flush_sequencer: counter plus done flag driving cache_inv_en and cache_inv_index.

Test Plan:
- Hit: cache_hit=1, addr 0x0000_0104, cache_rd_data 0xDEADBEEF -> fetch_rsp_valid 2 cycles after the handshake with data 0xDEADBEEF; no mem_req_valid.
- Miss:
  - Stimulus: addr 0x0000_1008, cache_hit=0, mem_req_ready delayed 3 cycles, beats 0x11, 0x22, 0x33, 0x44.
  - Required: mem_req_addr 0x0000_1000 held stable; 4 writes with offsets 0..3 at index 0; cache_tag_wr_en on the 4th beat with tag 0x8; response data 0x33.
- Flush in IDLE: pulse flush -> fetch_req_ready low, cache_inv_index sweeps 0..31 over 32 cycles, then fetch_req_ready returns high.
- Flush during FILL: flush pulsed after beat 1 -> the fill completes and the response is returned; the sweep starts afterwards; no request is accepted until the sweep ends.
- Reset mid-fill: assert reset after 2 beats -> all outputs 0 immediately; subsequent mem_rsp_valid beats produce no cache_wr_en; the next fetch is accepted normally.
- ICACHE_PERF_CNT_EN: 3 hits and 2 misses -> hit_count=3, miss_count=2; reset clears both.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types, field widths and address-split helpers for the instruction cache fill controller.
// The perf-counter option is selected with the ICACHE_PERF_CNT_EN macro in icache_fill_controller.sv.
package icache_pkg;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int NUM_LINES      = 32;
    localparam int WORDS_PER_LINE = 4;

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [OFF_W-1:0]  off_t;
    typedef logic [TAG_W-1:0]  tag_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        MEM_REQ = 3'd2,
        FILL    = 3'd3,
        RESP    = 3'd4,
        FLUSH   = 3'd5
    } icache_state_t;

    function automatic tag_t addr_tag(input addr_t addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic idx_t addr_index(input addr_t addr);
        return addr[2+OFF_W +: IDX_W];
    endfunction

    function automatic off_t addr_offset(input addr_t addr);
        return addr[2 +: OFF_W];
    endfunction

    // Rebuilds the line base address: word offset and byte bits forced to zero.
    function automatic addr_t line_addr(input tag_t tag, input idx_t idx);
        return {tag, idx, {(OFF_W+2){1'b0}}};
    endfunction

endpackage

// File: rtl/icache_fill_controller_if.sv
// Fetch, cache-array and memory-port signals of the fill controller.
// master = controller side, slave = fetch unit / arrays / memory side.
interface icache_fill_controller_if;
    import icache_pkg::*;

    logic              fetch_req_valid;
    logic              fetch_req_ready;
    logic [ADDR_W-1:0] fetch_req_addr;
    logic              fetch_rsp_valid;
    logic [DATA_W-1:0] fetch_rsp_data;

    logic [IDX_W-1:0]  cache_lookup_index;
    logic [OFF_W-1:0]  cache_lookup_offset;
    logic [TAG_W-1:0]  cache_lookup_tag;
    logic              cache_hit;
    logic [DATA_W-1:0] cache_rd_data;
    logic              cache_wr_en;
    logic [IDX_W-1:0]  cache_wr_index;
    logic [OFF_W-1:0]  cache_wr_offset;
    logic [DATA_W-1:0] cache_wr_data;
    logic              cache_tag_wr_en;
    logic              cache_inv_en;
    logic [IDX_W-1:0]  cache_inv_index;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;

    logic              flush;
    logic              busy;

    modport master (
        input  fetch_req_valid, fetch_req_addr,
        output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
        output cache_lookup_index, cache_lookup_offset, cache_lookup_tag,
        input  cache_hit, cache_rd_data,
        output cache_wr_en, cache_wr_index, cache_wr_offset, cache_wr_data,
        output cache_tag_wr_en, cache_inv_en, cache_inv_index,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  flush,
        output busy
    );

    modport slave (
        output fetch_req_valid, fetch_req_addr,
        input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data,
        input  cache_lookup_index, cache_lookup_offset, cache_lookup_tag,
        output cache_hit, cache_rd_data,
        input  cache_wr_en, cache_wr_index, cache_wr_offset, cache_wr_data,
        input  cache_tag_wr_en, cache_inv_en, cache_inv_index,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output flush,
        input  busy
    );

endinterface

// File: rtl/icache_flush_sequencer.sv
// Walks every cache line once, one per cycle, clearing its valid bit.
// done_o is high during the cycle that invalidates the last line.
module icache_flush_sequencer
    import icache_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    output logic inv_en_o,
    output idx_t inv_index_o,
    output logic done_o
);

    localparam idx_t LAST_IDX = idx_t'(NUM_LINES - 1);

    logic active_q;
    idx_t idx_q;

    // Sweep counter: armed by start_i, returns to index 0 after the last line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            idx_q    <= '0;
        end else if (active_q) begin
            if (idx_q == LAST_IDX) begin
                active_q <= 1'b0;
                idx_q    <= '0;
            end else begin
                idx_q <= idx_q + idx_t'(1);
            end
        end else if (start_i) begin
            active_q <= 1'b1;
            idx_q    <= '0;
        end else begin
            active_q <= 1'b0;
            idx_q    <= idx_q;
        end
    end

    assign inv_en_o    = active_q;
    assign inv_index_o = idx_q;
    assign done_o      = active_q && (idx_q == LAST_IDX);

endmodule

// File: rtl/icache_fill_controller.sv
// Instruction cache controller: lookup, line fill on miss, and full invalidate sweep.
// Define ICACHE_PERF_CNT_EN to add the hit_count/miss_count output ports.
module icache_fill_controller
    import icache_pkg::*;
(
    input  logic clk,
    input  logic reset,
    icache_fill_controller_if.master bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam off_t LAST_BEAT = off_t'(WORDS_PER_LINE - 1);

    icache_state_t state_q;
    addr_t         addr_q;
    off_t          beat_q;
    data_t         rsp_data_q;
    logic          rsp_valid_q;
    logic          mem_req_valid_q;
    logic          flush_pending_q;

    tag_t req_tag_s;
    idx_t req_idx_s;
    off_t req_off_s;
    logic fill_beat_s;
    logic flush_start_s;
    logic flush_done_s;
    logic inv_en_s;
    idx_t inv_index_s;

    assign req_tag_s     = addr_tag(addr_q);
    assign req_idx_s     = addr_index(addr_q);
    assign req_off_s     = addr_offset(addr_q);
    assign fill_beat_s   = (state_q == FILL) && bus.mem_rsp_valid;
    assign flush_start_s = (state_q == IDLE) && (flush_pending_q || bus.flush);

    // Main sequencer; a flush seen outside IDLE is parked until the current transaction ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            beat_q          <= '0;
            rsp_data_q      <= '0;
            rsp_valid_q     <= 1'b0;
            mem_req_valid_q <= 1'b0;
            flush_pending_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (bus.flush && (state_q != IDLE)) begin
                flush_pending_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (flush_pending_q || bus.flush) begin
                        state_q <= FLUSH;
                    end else if (bus.fetch_req_valid) begin
                        addr_q  <= bus.fetch_req_addr;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (bus.cache_hit) begin
                        rsp_data_q  <= bus.cache_rd_data;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        mem_req_valid_q <= 1'b1;
                        state_q         <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        beat_q          <= '0;
                        state_q         <= FILL;
                    end
                end
                FILL: begin
                    if (bus.mem_rsp_valid) begin
                        if (beat_q == req_off_s) begin
                            rsp_data_q <= bus.mem_rsp_data;
                        end
                        if (beat_q == LAST_BEAT) begin
                            beat_q      <= '0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            beat_q <= beat_q + off_t'(1);
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                FLUSH: begin
                    if (flush_done_s) begin
                        flush_pending_q <= 1'b0;
                        state_q         <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    icache_flush_sequencer u_flush_seq (
        .clk         (clk),
        .reset       (reset),
        .start_i     (flush_start_s),
        .inv_en_o    (inv_en_s),
        .inv_index_o (inv_index_s),
        .done_o      (flush_done_s)
    );

    // Ready is held low while reset is asserted so every output reads zero.
    assign bus.fetch_req_ready     = !reset && (state_q == IDLE) && !flush_pending_q && !bus.flush;
    assign bus.fetch_rsp_valid     = rsp_valid_q;
    assign bus.fetch_rsp_data      = rsp_data_q;
    assign bus.cache_lookup_index  = req_idx_s;
    assign bus.cache_lookup_offset = req_off_s;
    assign bus.cache_lookup_tag    = req_tag_s;
    assign bus.cache_wr_en         = fill_beat_s;
    assign bus.cache_wr_index      = req_idx_s;
    assign bus.cache_wr_offset     = beat_q;
    assign bus.cache_wr_data       = fill_beat_s ? bus.mem_rsp_data : '0;
    assign bus.cache_tag_wr_en     = fill_beat_s && (beat_q == LAST_BEAT);
    assign bus.cache_inv_en        = inv_en_s;
    assign bus.cache_inv_index     = inv_index_s;
    assign bus.mem_req_valid       = mem_req_valid_q;
    assign bus.mem_req_addr        = line_addr(req_tag_s, req_idx_s);
    assign bus.busy                = (state_q != IDLE);

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    // Lookup outcome counters, free-running with natural wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else if (state_q == LOOKUP) begin
            if (bus.cache_hit) begin
                hit_count_q <= hit_count_q + 32'd1;
            end else begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end else begin
            hit_count_q  <= hit_count_q;
            miss_count_q <= miss_count_q;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_fill_controller.sv
// Randomized bench for icache_fill_controller with a line-presence reference model and a memory image function.
module tb_icache_fill_controller;
    import icache_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    icache_fill_controller_if bus();

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_fill_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Cache arrays emulated by the bench, written only by the DUT's strobes.
    logic [DATA_W-1:0] env_data [NUM_LINES][WORDS_PER_LINE];
    logic [TAG_W-1:0]  env_tag  [NUM_LINES];
    bit                env_valid[NUM_LINES];
    logic              force_hit = 1'b0;
    logic [31:0]       force_data = 32'd0;

    always_comb begin
        if (force_hit) begin
            bus.cache_hit     = 1'b1;
            bus.cache_rd_data = force_data;
        end else begin
            bus.cache_hit     = env_valid[bus.cache_lookup_index] && (env_tag[bus.cache_lookup_index] == bus.cache_lookup_tag);
            bus.cache_rd_data = env_data[bus.cache_lookup_index][bus.cache_lookup_offset];
        end
    end

    always @(posedge clk) begin
        if (bus.cache_wr_en) env_data[bus.cache_wr_index][bus.cache_wr_offset] <= bus.cache_wr_data;
        if (bus.cache_tag_wr_en) begin
            env_tag[bus.cache_wr_index]   <= bus.cache_lookup_tag;
            env_valid[bus.cache_wr_index] <= 1'b1;
        end
        if (bus.cache_inv_en) env_valid[bus.cache_inv_index] <= 1'b0;
    end

    // Reference model: which line address each index currently holds.
    bit          ref_valid[NUM_LINES];
    logic [31:0] ref_tag  [NUM_LINES];
    int          exp_hits = 0;
    int          exp_miss = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if ((a >> 4) == 32'h100) return 32'h11 * (32'((a >> 2) % 4) + 32'd1);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic accept(input logic [31:0] addr);
        bit ok = 1'b0;
        bus.fetch_req_valid = 1'b1;
        bus.fetch_req_addr  = addr;
        for (int i = 0; i < 200; i++) begin
            if (bus.fetch_req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    // Full transaction from handshake to response, acting as the memory.
    task automatic fetch(input logic [31:0] addr, input int rdy_dly, input bit gaps, input bit flush_mid,
                         output logic [31:0] data, output bit missed, output int lat, output int gapn);
        logic [31:0] line;
        int  beat = 0, waitc = 0;
        bit  filling = 1'b0, got = 1'b0, seen = 1'b0, pend_flush = 1'b0;
        line   = addr - (addr % (4 * WORDS_PER_LINE));
        missed = 1'b0;
        gapn   = 0;
        lat    = 0;
        data   = 32'd0;
        accept(addr);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            bus.fetch_req_valid = 1'b0;
            bus.mem_req_ready   = 1'b0;
            bus.mem_rsp_valid   = 1'b0;
            bus.mem_rsp_data    = 32'd0;
            bus.flush           = pend_flush;
            pend_flush          = 1'b0;
            if (bus.fetch_rsp_valid) begin
                data = bus.fetch_rsp_data;
                lat  = c;
                got  = 1'b1;
                break;
            end
            if (bus.mem_req_valid) begin
                missed = 1'b1;
                if (!seen) begin
                    seen = 1'b1;
                    check_eq("mem_addr", bus.mem_req_addr, line);
                end
                if (waitc == rdy_dly) begin
                    check_eq("mem_addr_hold", bus.mem_req_addr, line);
                    bus.mem_req_ready = 1'b1;
                    filling = 1'b1;
                end else begin
                    waitc++;
                end
            end else if (filling && beat < WORDS_PER_LINE) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    gapn++;
                    #1 check_eq("no_wr_gap", 32'(bus.cache_wr_en), 32'd0);
                end else begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_data  = mem_word(line + 32'(4 * beat));
                    #1;
                    check_eq("wr_en", 32'(bus.cache_wr_en), 32'd1);
                    check_eq("wr_off", 32'(bus.cache_wr_offset), 32'(beat));
                    check_eq("wr_idx", 32'(bus.cache_wr_index), (addr / (4 * WORDS_PER_LINE)) % NUM_LINES);
                    check_eq("wr_data", bus.cache_wr_data, mem_word(line + 32'(4 * beat)));
                    check_eq("tag_wr", 32'(bus.cache_tag_wr_en), 32'(beat == WORDS_PER_LINE - 1));
                    if (beat == WORDS_PER_LINE - 1)
                        check_eq("tag_val", 32'(bus.cache_lookup_tag), addr >> (ADDR_W - TAG_W));
                    if (flush_mid && beat == 1) pend_flush = 1'b1;
                    beat++;
                end
            end
        end
        if (!got) check_eq("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input int rdy_dly, input bit gaps, input bit flush_mid,
                            output logic [31:0] data);
        int  idx, lat, gapn;
        bit  missed, pred_hit;
        logic [31:0] tag;
        idx      = (addr / (4 * WORDS_PER_LINE)) % NUM_LINES;
        tag      = addr >> (ADDR_W - TAG_W);
        pred_hit = ref_valid[idx] && (ref_tag[idx] == tag);
        fetch(addr, rdy_dly, gaps, flush_mid, data, missed, lat, gapn);
        check_eq("hit_miss", 32'(missed), 32'(!pred_hit));
        check_eq("rsp_data", data, mem_word(addr & ~32'd3));
        check_eq("latency", 32'(lat), pred_hit ? 32'd2 : 32'(2 + rdy_dly + WORDS_PER_LINE + 1 + gapn));
        if (pred_hit) begin
            exp_hits++;
        end else begin
            exp_miss++;
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tag;
        end
    endtask

    task automatic watch_sweep();
        int cnt = 0;
        for (int i = 0; i < 80; i++) begin
            if (bus.cache_inv_en) begin
                check_eq("inv_idx", 32'(bus.cache_inv_index), 32'(cnt));
                if (cnt == NUM_LINES / 2) check_eq("rdy_in_sweep", 32'(bus.fetch_req_ready), 32'd0);
                cnt++;
            end else if (cnt > 0) begin
                break;
            end
            @(negedge clk);
        end
        check_eq("sweep_len", 32'(cnt), 32'(NUM_LINES));
        check_eq("rdy_after_sweep", 32'(bus.fetch_req_ready), 32'd1);
        for (int i = 0; i < NUM_LINES; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic flush_idle();
        @(negedge clk);
        bus.flush = 1'b1;
        #1 check_eq("rdy_on_flush", 32'(bus.fetch_req_ready), 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        watch_sweep();
    endtask

    initial begin
        logic [31:0] d, a;
        bit          m;
        int          lat, gapn;
        bus.fetch_req_valid = 1'b0;
        bus.fetch_req_addr  = 32'd0;
        bus.mem_req_ready   = 1'b0;
        bus.mem_rsp_valid   = 1'b0;
        bus.mem_rsp_data    = 32'd0;
        bus.flush           = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_ready_low", 32'(bus.fetch_req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("rst_ready", 32'(bus.fetch_req_ready), 32'd1);
        check_eq("rst_mreq", 32'(bus.mem_req_valid), 32'd0);
        check_eq("rst_rsp", 32'(bus.fetch_rsp_valid), 32'd0);
        check_eq("rst_inv", 32'(bus.cache_inv_en), 32'd0);

        // Directed hit with forced array response.
        @(negedge clk);
        force_hit  = 1'b1;
        force_data = 32'hDEAD_BEEF;
        fetch(32'h0000_0104, 0, 1'b0, 1'b0, d, m, lat, gapn);
        force_hit = 1'b0;
        check_eq("hit_data", d, 32'hDEAD_BEEF);
        check_eq("hit_nomem", 32'(m), 32'd0);
        check_eq("hit_lat", 32'(lat), 32'd2);
        exp_hits++;

        // Directed miss with a delayed memory handshake.
        do_fetch(32'h0000_1008, 3, 1'b0, 1'b0, d);
        check_eq("miss_data", d, 32'h33);
        do_fetch(32'h0000_1008, 0, 1'b0, 1'b0, d);

        flush_idle();
        do_fetch(32'h0000_0230, 1, 1'b0, 1'b1, d);
        watch_sweep();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                flush_idle();
            end else begin
                a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 4) |
                    (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
                do_fetch(a, $urandom_range(0, 3), 1'b1, 1'b0, d);
            end
        end

`ifdef ICACHE_PERF_CNT_EN
        check_eq("hit_cnt", hit_count, 32'(exp_hits));
        check_eq("miss_cnt", miss_count, 32'(exp_miss));
`endif

        // Reset in the middle of a fill.
        flush_idle();
        accept(32'h0000_2244);
        @(negedge clk);
        bus.fetch_req_valid = 1'b0;
        @(negedge clk);
        check_eq("rf_mreq", 32'(bus.mem_req_valid), 32'd1);
        bus.mem_req_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = 32'hBAD0_0000 + 32'(b);
        end
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("rf_busy", 32'(bus.busy), 32'd0);
        check_eq("rf_mreq0", 32'(bus.mem_req_valid), 32'd0);
        check_eq("rf_maddr", bus.mem_req_addr, 32'd0);
        check_eq("rf_tagwr", 32'(bus.cache_tag_wr_en), 32'd0);
        check_eq("rf_ready", 32'(bus.fetch_req_ready), 32'd0);
        check_eq("rf_ltag", 32'(bus.cache_lookup_tag), 32'd0);
`ifdef ICACHE_PERF_CNT_EN
        check_eq("rf_hit_cnt", hit_count, 32'd0);
        check_eq("rf_miss_cnt", miss_count, 32'd0);
        exp_hits = 0;
        exp_miss = 0;
`endif
        @(negedge clk);
        reset = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = 32'hBAD0_0002 + 32'(b);
            #1 check_eq("rf_no_wr", 32'(bus.cache_wr_en), 32'd0);
            check_eq("rf_ready_up", 32'(bus.fetch_req_ready), 32'd1);
            @(negedge clk);
        end
        bus.mem_rsp_valid = 1'b0;
        do_fetch(32'h0000_2244, 1, 1'b0, 1'b0, d);

`ifdef ICACHE_PERF_CNT_EN
        check_eq("end_hit_cnt", hit_count, 32'(exp_hits));
        check_eq("end_miss_cnt", miss_count, 32'(exp_miss));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
